ras_ckpt_stack: RTL

RAS_CKPT_STACK -- requirements
Module: ras_ckpt_stack

---
 rtl/ras_ckpt_stack.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with checkpoint/restore of its pointer state.
// Speculative calls push and returns pop; a mispredict reloads {tp, occ}.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                empty the stack (entries kept)
//   push_i, pop_i, data_i  speculative call / return, pushed address
//   restore_i, ckpt_i      reload {tp, occ} from an earlier ckpt_o
//   top_valid_o, top_o     stack non-empty, entry at top pointer
//   ckpt_o                 current {tp, occ}
//   overflow_o             push discarded the oldest entry (this cycle)
//   underflow_o            pop on empty stack (this cycle)
module ras_ckpt_stack #(
    parameter  int VLEN   = 64,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int CKPT_W = PTR_W + CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [VLEN-1:0]   data_i,
    input  logic              restore_i,
    input  logic [CKPT_W-1:0] ckpt_i,
    output logic              top_valid_o,
    output logic [VLEN-1:0]   top_o,
    output logic [CKPT_W-1:0] ckpt_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] OCC_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [VLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_tp;
    logic [CNT_W-1:0] r_occ;

    logic [PTR_W-1:0] w_tp_nxt;
    logic [PTR_W-1:0] w_tp_inc;
    logic [PTR_W-1:0] w_tp_dec;
    logic [PTR_W-1:0] w_ckpt_tp;
    logic [PTR_W-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_ckpt_occ;
    logic             w_empty;
    logic             w_full;
    logic             w_spec_op;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_push_pop;
    logic             w_wr_en;

    // Pointer width equals log2(DEPTH), so natural wrap is modulo DEPTH.
    assign w_tp_inc   = r_tp + PTR_ONE;
    assign w_tp_dec   = r_tp - PTR_ONE;
    assign w_ckpt_tp  = ckpt_i[CKPT_W-1:CNT_W];
    assign w_ckpt_occ = ckpt_i[CNT_W-1:0];

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == OCC_FULL);

    // Push/pop only act when neither flush nor restore claims the cycle.
    assign w_spec_op   = !flush_i && !restore_i;
    assign w_push_only = w_spec_op && push_i && !pop_i;
    assign w_pop_only  = w_spec_op && pop_i && !push_i;
    assign w_push_pop  = w_spec_op && push_i && pop_i;

    // Push+pop replaces the top in place: the return leaves and the call
    // re-enters at the same slot.
    assign w_wr_en  = w_push_only || w_push_pop;
    assign w_wr_idx = w_push_only ? w_tp_inc : r_tp;

    always_comb begin
        w_tp_nxt  = r_tp;
        w_occ_nxt = r_occ;
        if (flush_i) begin
            w_tp_nxt  = '0;
            w_occ_nxt = '0;
        end else if (restore_i) begin
            w_tp_nxt  = w_ckpt_tp;
            w_occ_nxt = w_ckpt_occ;
        end else if (w_push_pop) begin
            if (w_empty) begin
                w_occ_nxt = OCC_ONE;
            end
        end else if (w_push_only) begin
            w_tp_nxt = w_tp_inc;
            if (!w_full) begin
                w_occ_nxt = r_occ + OCC_ONE;
            end
        end else if (w_pop_only) begin
            if (!w_empty) begin
                w_tp_nxt  = w_tp_dec;
                w_occ_nxt = r_occ - OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tp  <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_tp  <= w_tp_nxt;
            r_occ <= w_occ_nxt;
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= data_i;
            end
        end
    end

    assign top_o       = r_mem[r_tp];
    assign top_valid_o = !w_empty;
    assign ckpt_o      = {r_tp, r_occ};
    assign overflow_o  = w_push_only && w_full;
    assign underflow_o = w_pop_only && w_empty;

    // A checkpoint can only ever carry an occupancy of 0..DEPTH.
    a_ckpt_occ_legal: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (restore_i && !flush_i) |-> (w_ckpt_occ <= OCC_FULL)
    );

endmodule
